trap_peak_detector: RTL and testbench
=====================================

TRAP_PEAK_DETECTOR -- requirements
Module: trap_peak_detector

Interface
REQ-001 SHALL declare parameter SIZE_OUT_DATA, default from package_settings_V1; sets trap_data, threshold and ev_amp width.
REQ-002 SHALL declare parameter TS_WIDTH, default 32; sets timestamp width.
REQ-003 SHALL declare parameter HOLDOFF_CYCLES, default 8; sets the dead time after each pulse.
REQ-004 SHALL declare parameter WIDTH_BITS, default 8; sets the pulse-width counter width.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 trap_data  in  SIZE_OUT_DATA  signed trapezoid sample, one per clk, from the shaping filter.
REQ-008 threshold  in  SIZE_OUT_DATA  signed trigger level; sampled only while in IDLE.
REQ-009 ev_ready  in  1  consumer accepts the event.
REQ-010 ev_valid  out  1  event payload valid.
REQ-011 ev_amp  out  SIZE_OUT_DATA  signed peak amplitude.
REQ-012 ev_time  out  TS_WIDTH  timestamp of the peak sample.
REQ-013 ev_width  out  WIDTH_BITS  number of samples above threshold.
REQ-014 ev_pileup  out  1  pulse began inside the previous pulse's holdoff window.
REQ-015 drop_cnt  out  16  count of events lost to backpressure.
REQ-016 busy  out  1  FSM not in IDLE.

Function
REQ-017 SHALL register trap_data once (sample register); all decisions use the registered sample.
REQ-018 SHALL keep a free-running TS_WIDTH counter, 0 after reset, +1 per clk, wrapping at all-ones; the sample register SHALL capture the counter value alongside each sample.
REQ-019 SHALL compare samples against the threshold as signed values; a sample is "above" only if strictly greater than the threshold.
REQ-020 SHALL use FSM states IDLE, ARMED and HOLDOFF.
REQ-021 IDLE->ARMED on an above sample: latch the threshold, set max = sample, peak_ts = its timestamp, width = 1.
REQ-022 In ARMED, an above sample SHALL increment width, saturating at all-ones; it SHALL update max/peak_ts only if the sample is strictly greater than max (first peak of a flat top wins).
REQ-023 ARMED->HOLDOFF on the first sample at or below the threshold; the event SHALL be emitted on that transition and the holdoff counter loaded with HOLDOFF_CYCLES-1.
REQ-024 HOLDOFF SHALL decrement the counter, then go to IDLE at 0; an above sample seen during HOLDOFF SHALL set the pending-pileup bit; HOLDOFF always runs to completion.
REQ-025 The next event SHALL carry ev_pileup = pending-pileup; the bit SHALL clear once that event is emitted.
REQ-026 Latency: ev_valid SHALL rise at the 2nd posedge after the posedge at which the first at/below sample is presented on trap_data.
REQ-027 Handshake: the payload SHALL stay stable while ev_valid=1 and ev_ready=0; transfer SHALL occur on a posedge with both high; ev_valid SHALL drop the next cycle unless a new event loads.
REQ-028 Emission while ev_valid=1 and no transfer on that edge: the new event SHALL be discarded and drop_cnt incremented, saturating at 16'hFFFF.
REQ-029 Emission on the same edge as a transfer SHALL load the new event with ev_valid held high and no drop.

Reset
REQ-030 reset=0 at a posedge SHALL clear: FSM to IDLE, ev_valid/ev_amp/ev_time/ev_width/ev_pileup to 0, drop_cnt to 0, timestamp to 0, sample register to 0, pending-pileup to 0.
REQ-031 Reset mid-pulse SHALL discard the partial pulse; no event SHALL be emitted from it after release.

Structure
REQ-032 SIZE_OUT_DATA, TS_WIDTH, HOLDOFF_CYCLES, WIDTH_BITS and the FSM state enum typedef SHALL live in package_settings_V1.
REQ-033 The output event register plus handshake/drop logic SHALL be sub-module trap_event_buffer; the FSM/peak logic stays in the top.

Verification (SIZE_OUT_DATA=16, HOLDOFF_CYCLES=8, threshold=100)
REQ-034 Triangle 0,50,...,500,...,0, ev_ready=1 -> one event: amp=500, width=15, time=timestamp of the 500 sample, pileup=0, ev_valid high 1 cycle.
REQ-035 Ramp to flat top 300 for 10 cycles, then fall -> amp=300, time=timestamp of the first 300 sample.
REQ-036 ev_ready=0; two triangles 40 cycles apart -> first payload held unchanged, second dropped, drop_cnt=1; then ev_ready=1 -> first transfers, ev_valid=0 next cycle.
REQ-037 Second triangle crossing 3 cycles after the first falls below threshold -> second pulse ignored during holdoff; next pulse after holdoff reports pileup=1.
REQ-038 Constant -200 for 100 cycles -> no event, busy=0; reset=0 asserted mid-pulse at amp 300 -> ev_valid=0, no event after release.

Source files
------------

// File: rtl/trap_peak_detector_pkg.sv
// Shared settings for the trapezoid peak detector: default widths, holdoff length,
// FSM state encoding and a small saturating-counter helper.
package package_settings_V1;

  localparam int SIZE_OUT_DATA  = 16;
  localparam int TS_WIDTH       = 32;
  localparam int HOLDOFF_CYCLES = 8;
  localparam int WIDTH_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/trap_peak_detector_event_buffer.sv
// Output event register with valid/ready handshake; events arriving while an
// untransferred event is held are discarded and counted.
module trap_event_buffer #(
  parameter int SIZE_OUT_DATA = package_settings_V1::SIZE_OUT_DATA,
  parameter int TS_WIDTH      = package_settings_V1::TS_WIDTH,
  parameter int WIDTH_BITS    = package_settings_V1::WIDTH_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            emit,
  input  logic signed [SIZE_OUT_DATA-1:0] emit_amp,
  input  logic [TS_WIDTH-1:0]             emit_ts,
  input  logic [WIDTH_BITS-1:0]           emit_width,
  input  logic                            emit_pileup,
  input  logic                            ev_ready,
  output logic                            ev_valid,
  output logic signed [SIZE_OUT_DATA-1:0] ev_amp,
  output logic [TS_WIDTH-1:0]             ev_time,
  output logic [WIDTH_BITS-1:0]           ev_width,
  output logic                            ev_pileup,
  output logic [15:0]                     drop_cnt
);
  import package_settings_V1::*;

  logic xfer_s;
  logic load_s;
  logic drop_s;

  // A new event may overwrite the register only if it is empty or emptying on this edge.
  always_comb begin
    xfer_s = ev_valid & ev_ready;
    load_s = 1'b0;
    drop_s = 1'b0;
    if (emit) begin
      if (!ev_valid || xfer_s) begin
        load_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Event payload, valid flag and drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ev_valid  <= 1'b0;
      ev_amp    <= '0;
      ev_time   <= '0;
      ev_width  <= '0;
      ev_pileup <= 1'b0;
      drop_cnt  <= 16'd0;
    end else begin
      if (load_s) begin
        ev_valid  <= 1'b1;
        ev_amp    <= emit_amp;
        ev_time   <= emit_ts;
        ev_width  <= emit_width;
        ev_pileup <= emit_pileup;
      end else if (xfer_s) begin
        ev_valid <= 1'b0;
      end
      if (drop_s) begin
        drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

endmodule

// File: rtl/trap_peak_detector.sv
// Peak detector for trapezoid-shaped pulses: tracks the first maximum above a
// latched threshold, measures pulse width and flags pile-up inside the dead time.
module trap_peak_detector #(
  parameter int SIZE_OUT_DATA  = package_settings_V1::SIZE_OUT_DATA,
  parameter int TS_WIDTH       = package_settings_V1::TS_WIDTH,
  parameter int HOLDOFF_CYCLES = package_settings_V1::HOLDOFF_CYCLES,
  parameter int WIDTH_BITS     = package_settings_V1::WIDTH_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [SIZE_OUT_DATA-1:0] trap_data,
  input  logic signed [SIZE_OUT_DATA-1:0] threshold,
  input  logic                            ev_ready,
  output logic                            ev_valid,
  output logic signed [SIZE_OUT_DATA-1:0] ev_amp,
  output logic [TS_WIDTH-1:0]             ev_time,
  output logic [WIDTH_BITS-1:0]           ev_width,
  output logic                            ev_pileup,
  output logic [15:0]                     drop_cnt,
  output logic                            busy
);
  import package_settings_V1::*;

  localparam int HC_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic [TS_WIDTH-1:0]             ts_r;
  logic signed [SIZE_OUT_DATA-1:0] sample_r;
  logic [TS_WIDTH-1:0]             sample_ts_r;

  state_t                          state_r, state_nxt_s;
  logic signed [SIZE_OUT_DATA-1:0] thr_r, thr_nxt_s;
  logic signed [SIZE_OUT_DATA-1:0] max_r, max_nxt_s;
  logic [TS_WIDTH-1:0]             peak_ts_r, peak_ts_nxt_s;
  logic [WIDTH_BITS-1:0]           width_r, width_nxt_s;
  logic [HC_W-1:0]                 hold_cnt_r, hold_cnt_nxt_s;
  logic                            pend_r, pend_nxt_s;
  logic                            busy_r;

  logic                            emit_r, emit_nxt_s;
  logic signed [SIZE_OUT_DATA-1:0] emit_amp_r, emit_amp_nxt_s;
  logic [TS_WIDTH-1:0]             emit_ts_r, emit_ts_nxt_s;
  logic [WIDTH_BITS-1:0]           emit_width_r, emit_width_nxt_s;
  logic                            emit_pileup_r, emit_pileup_nxt_s;

  logic above_idle_s;
  logic above_latched_s;
  logic new_max_s;

  assign above_idle_s    = (sample_r > threshold);
  assign above_latched_s = (sample_r > thr_r);
  assign new_max_s       = (sample_r > max_r);
  assign busy            = busy_r;

  // Input sample register paired with the free-running timestamp.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_r        <= '0;
      sample_r    <= '0;
      sample_ts_r <= '0;
    end else begin
      ts_r        <= ts_r + TS_WIDTH'(1'b1);
      sample_r    <= trap_data;
      sample_ts_r <= ts_r;
    end
  end

  // Next-state and peak-tracking decisions.
  always_comb begin
    state_nxt_s       = state_r;
    thr_nxt_s         = thr_r;
    max_nxt_s         = max_r;
    peak_ts_nxt_s     = peak_ts_r;
    width_nxt_s       = width_r;
    hold_cnt_nxt_s    = hold_cnt_r;
    pend_nxt_s        = pend_r;
    emit_nxt_s        = 1'b0;
    emit_amp_nxt_s    = emit_amp_r;
    emit_ts_nxt_s     = emit_ts_r;
    emit_width_nxt_s  = emit_width_r;
    emit_pileup_nxt_s = emit_pileup_r;
    case (state_r)
      IDLE: begin
        if (above_idle_s) begin
          state_nxt_s   = ARMED;
          thr_nxt_s     = threshold;
          max_nxt_s     = sample_r;
          peak_ts_nxt_s = sample_ts_r;
          width_nxt_s   = WIDTH_BITS'(1'b1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (above_latched_s) begin
          if (width_r != '1) begin
            width_nxt_s = width_r + WIDTH_BITS'(1'b1);
          end else begin
            width_nxt_s = width_r;
          end
          // Strictly greater: on a flat top the earliest sample keeps the timestamp.
          if (new_max_s) begin
            max_nxt_s     = sample_r;
            peak_ts_nxt_s = sample_ts_r;
          end else begin
            max_nxt_s = max_r;
          end
        end else begin
          state_nxt_s       = HOLDOFF;
          hold_cnt_nxt_s    = HC_W'(HOLDOFF_CYCLES - 1);
          emit_nxt_s        = 1'b1;
          emit_amp_nxt_s    = max_r;
          emit_ts_nxt_s     = peak_ts_r;
          emit_width_nxt_s  = width_r;
          emit_pileup_nxt_s = pend_r;
          pend_nxt_s        = 1'b0;
        end
      end
      HOLDOFF: begin
        if (above_latched_s) begin
          pend_nxt_s = 1'b1;
        end else begin
          pend_nxt_s = pend_r;
        end
        if (hold_cnt_r == '0) begin
          state_nxt_s = IDLE;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - HC_W'(1'b1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM and pulse-tracking state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      thr_r         <= '0;
      max_r         <= '0;
      peak_ts_r     <= '0;
      width_r       <= '0;
      hold_cnt_r    <= '0;
      pend_r        <= 1'b0;
      busy_r        <= 1'b0;
      emit_r        <= 1'b0;
      emit_amp_r    <= '0;
      emit_ts_r     <= '0;
      emit_width_r  <= '0;
      emit_pileup_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      thr_r         <= thr_nxt_s;
      max_r         <= max_nxt_s;
      peak_ts_r     <= peak_ts_nxt_s;
      width_r       <= width_nxt_s;
      hold_cnt_r    <= hold_cnt_nxt_s;
      pend_r        <= pend_nxt_s;
      busy_r        <= (state_nxt_s != IDLE);
      emit_r        <= emit_nxt_s;
      emit_amp_r    <= emit_amp_nxt_s;
      emit_ts_r     <= emit_ts_nxt_s;
      emit_width_r  <= emit_width_nxt_s;
      emit_pileup_r <= emit_pileup_nxt_s;
    end
  end

  trap_event_buffer #(
    .SIZE_OUT_DATA(SIZE_OUT_DATA),
    .TS_WIDTH     (TS_WIDTH),
    .WIDTH_BITS   (WIDTH_BITS)
  ) u_event_buffer (
    .clk        (clk),
    .reset      (reset),
    .emit       (emit_r),
    .emit_amp   (emit_amp_r),
    .emit_ts    (emit_ts_r),
    .emit_width (emit_width_r),
    .emit_pileup(emit_pileup_r),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_amp     (ev_amp),
    .ev_time    (ev_time),
    .ev_width   (ev_width),
    .ev_pileup  (ev_pileup),
    .drop_cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_trap_peak_detector.sv
// Directed-vector bench for trap_peak_detector (16-bit data, holdoff 8, threshold 100).
module tb_trap_peak_detector;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] trap_data;
  logic signed [15:0] threshold;
  logic               ev_ready;
  logic               ev_valid;
  logic signed [15:0] ev_amp;
  logic [31:0]        ev_time;
  logic [7:0]         ev_width;
  logic               ev_pileup;
  logic [15:0]        drop_cnt;
  logic               busy;

  always #5 clk = ~clk;

  trap_peak_detector #(
    .SIZE_OUT_DATA (16),
    .TS_WIDTH      (32),
    .HOLDOFF_CYCLES(8),
    .WIDTH_BITS    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trap_data(trap_data),
    .threshold(threshold),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_amp   (ev_amp),
    .ev_time  (ev_time),
    .ev_width (ev_width),
    .ev_pileup(ev_pileup),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference timestamp: value the DUT counter holds between edges.
  logic [31:0] tb_ts;
  always @(posedge clk) tb_ts <= reset ? tb_ts + 32'd1 : 32'd0;

  // Event monitor, sampled mid-cycle after each rising edge.
  int          ev_count = 0;
  int          valid_cycles = 0;
  int          busy_cycles = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] cap_amp;
  logic [31:0] cap_time;
  logic [31:0] cap_seen;
  logic [7:0]  cap_width;
  logic        cap_pileup;
  always @(posedge clk) begin
    #2;
    if (ev_valid && !prev_valid) begin
      ev_count++;
      cap_amp    = ev_amp;
      cap_time   = ev_time;
      cap_width  = ev_width;
      cap_pileup = ev_pileup;
      cap_seen   = tb_ts;
    end
    if (ev_valid) valid_cycles++;
    if (busy) busy_cycles++;
    prev_valid = ev_valid;
  end

  task automatic push(input int v);
    trap_data = 16'(v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) push(0);
  endtask

  task automatic tri_pulse(input int top, output logic [31:0] peak_ts, output logic [31:0] fall_ts);
    bit got;
    got = 1'b0;
    fall_ts = 32'd0;
    for (int v = 0; v < top; v += 50) push(v);
    peak_ts = tb_ts;
    push(top);
    for (int v = top - 50; v >= 0; v -= 50) begin
      if (!got && v <= 100) begin
        fall_ts = tb_ts;
        got = 1'b1;
      end
      push(v);
    end
  endtask

  logic [31:0] pk, fl, sa;
  int base, vbase, bbase;

  initial begin
    reset = 1'b0;
    trap_data = 16'sd0;
    threshold = 16'sd100;
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_amp", ev_amp, 0);
    check_eq("rst_width", ev_width, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    idle(5);

    // Single triangle, consumer always ready
    base = ev_count; vbase = valid_cycles;
    tri_pulse(500, pk, fl);
    idle(12);
    check_eq("tri_count", ev_count - base, 1);
    check_eq("tri_amp", cap_amp, 500);
    check_eq("tri_width", cap_width, 15);
    check_eq("tri_time", cap_time, pk);
    check_eq("tri_pileup", cap_pileup, 0);
    check_eq("tri_latency", cap_seen, fl + 32'd3);
    check_eq("tri_valid_cycles", valid_cycles - vbase, 1);
    check_eq("tri_busy_end", busy, 0);

    // Flat top: first 300 sample owns the timestamp
    base = ev_count;
    for (int v = 0; v < 300; v += 50) push(v);
    pk = tb_ts;
    repeat (10) push(300);
    for (int v = 250; v >= 0; v -= 50) push(v);
    idle(12);
    check_eq("flat_count", ev_count - base, 1);
    check_eq("flat_amp", cap_amp, 300);
    check_eq("flat_time", cap_time, pk);
    check_eq("flat_width", cap_width, 16);

    // Backpressure: second event dropped, first held
    ev_ready = 1'b0;
    base = ev_count;
    sa = tb_ts;
    tri_pulse(500, pk, fl);
    while (tb_ts != sa + 32'd40) push(0);
    tri_pulse(400, fl, sa);
    idle(15);
    check_eq("bp_count", ev_count - base, 1);
    check_eq("bp_valid", ev_valid, 1);
    check_eq("bp_amp_held", ev_amp, 500);
    check_eq("bp_time_held", ev_time, pk);
    check_eq("bp_width_held", ev_width, 15);
    check_eq("bp_drop", drop_cnt, 1);
    ev_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release", ev_valid, 0);

    // Pile-up: pulse inside holdoff ignored, flagged on next event
    base = ev_count;
    tri_pulse(500, pk, fl);
    push(200); push(300); push(200);
    idle(20);
    check_eq("pu_first_count", ev_count - base, 1);
    check_eq("pu_first_amp", cap_amp, 500);
    check_eq("pu_first_flag", cap_pileup, 0);
    base = ev_count;
    tri_pulse(400, pk, fl);
    idle(12);
    check_eq("pu_next_count", ev_count - base, 1);
    check_eq("pu_next_flag", cap_pileup, 1);
    check_eq("pu_next_amp", cap_amp, 400);
    check_eq("pu_next_width", cap_width, 11);
    check_eq("pu_next_time", cap_time, pk);
    tri_pulse(250, pk, fl);
    idle(12);
    check_eq("pu_clear_flag", cap_pileup, 0);
    check_eq("pu_clear_width", cap_width, 5);

    // Negative samples never trigger
    base = ev_count; bbase = busy_cycles;
    repeat (100) push(-200);
    check_eq("neg_count", ev_count - base, 0);
    check_eq("neg_busy_cycles", busy_cycles - bbase, 0);
    check_eq("neg_busy", busy, 0);
    idle(2);

    // Width counter saturates
    base = ev_count;
    pk = tb_ts;
    repeat (300) push(300);
    idle(12);
    check_eq("sat_count", ev_count - base, 1);
    check_eq("sat_width", cap_width, 255);
    check_eq("sat_amp", cap_amp, 300);
    check_eq("sat_time", cap_time, pk);

    // Reset mid-pulse discards the partial pulse
    base = ev_count;
    for (int v = 0; v <= 300; v += 50) push(v);
    reset = 1'b0;
    trap_data = 16'sd0;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_valid", ev_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_drop", drop_cnt, 0);
    reset = 1'b1;
    idle(20);
    check_eq("mid_rst_no_event", ev_count - base, 0);
    check_eq("mid_rst_valid_after", ev_valid, 0);

    // Timestamp restarted from zero after reset
    base = ev_count;
    tri_pulse(500, pk, fl);
    idle(12);
    check_eq("post_rst_count", ev_count - base, 1);
    check_eq("post_rst_time", cap_time, pk);
    check_eq("post_rst_amp", cap_amp, 500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
